// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin UART TX byte arbiter with per-line locking
module uart_tx_arbiter #(
    parameter int          NumReq        = 4,
    parameter int          TimeoutCycles = 1024,
    parameter logic [7:0]  LineTerm      = 8'h0A,
    localparam int         IdW           = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [NumReq*8-1:0]   req_data_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic [NumReq-1:0]     grant_o,
    output logic [IdW-1:0]        owner_o,
    output logic                  busy_o,
    output logic                  timeout_o
);

    localparam int              CntW    = $clog2(TimeoutCycles);
    localparam logic [IdW-1:0]  LastId  = IdW'(NumReq - 1);
    localparam logic [IdW:0]    NumReqW = (IdW + 1)'(NumReq);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IdW-1:0]  r_owner;
    logic [IdW-1:0]  r_rr_ptr;
    logic [CntW-1:0] r_idle_cnt;
    logic            r_timeout;

    logic [IdW:0]    w_idx;
    logic [IdW-1:0]  w_sel;
    logic [IdW-1:0]  w_next_ptr;
    logic            w_found;
    logic            w_own_valid;
    logic [7:0]      w_own_data;
    logic            w_hs;
    logic            w_term;
    logic            w_tmo;

    // Walk from the highest offset down so the request nearest rr_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + (IdW + 1)'(i);
            if (w_idx >= NumReqW) begin
                w_idx = w_idx - NumReqW;
            end
            if (req_valid_i[w_idx[IdW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IdW-1:0];
            end
        end
    end

    assign w_own_valid = req_valid_i[r_owner];
    assign w_own_data  = req_data_i[{r_owner, 3'b000} +: 8];
    assign w_hs        = (r_state == S_LOCKED) && w_own_valid && tx_ready_i;
    assign w_term      = w_hs && (w_own_data == LineTerm);
    // Only an absent owner byte can time out, so stalls never drop the lock.
    assign w_tmo       = (r_state == S_LOCKED) && !w_own_valid && (r_idle_cnt == CntLast);
    assign w_next_ptr  = (r_owner == LastId) ? '0 : r_owner + IdW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found)          w_state_next = S_LOCKED;
            S_LOCKED: if (w_term || w_tmo)  w_state_next = S_IDLE;
            default:                        w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        grant_o     = '0;
        busy_o      = 1'b0;
        owner_o     = '0;
        if (r_state == S_LOCKED) begin
            tx_valid_o           = w_own_valid;
            tx_data_o            = w_own_data;
            req_ready_o[r_owner] = tx_ready_i;
            grant_o[r_owner]     = 1'b1;
            busy_o               = 1'b1;
            owner_o              = r_owner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_tmo;
            if (r_state == S_IDLE) begin
                if (w_found) begin
                    r_owner    <= w_sel;
                    r_idle_cnt <= '0;
                end
            end else begin
                if (w_hs) begin
                    r_idle_cnt <= '0;
                end else if (!w_own_valid) begin
                    r_idle_cnt <= r_idle_cnt + CntW'(1);
                end
                if (w_term || w_tmo) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end
        end
    end

    assign timeout_o = r_timeout;

endmodule
